// File: rtl/stream_scheduler.sv
// stream_scheduler: round-robin mux of per-stream producers onto one filter, in-order return to sinks, zero-stuffing of silent slots
module stream_scheduler #(
    parameter int DWIDTH         = 16,
    parameter int NR_STREAMS     = 13,
    parameter int NR_STREAMS_LOG = 4,
    parameter int STUFF_TIMEOUT  = 8,
    parameter int FIFO_LOG       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NR_STREAMS-1:0]        src_req,
    output logic [NR_STREAMS-1:0]        src_ack,
    input  logic [NR_STREAMS*DWIDTH-1:0] src_data,
    output logic                         flt_in_req,
    input  logic                         flt_in_ack,
    output logic [DWIDTH-1:0]            flt_in_data,
    input  logic                         flt_out_req,
    output logic                         flt_out_ack,
    input  logic [DWIDTH-1:0]            flt_out_data,
    output logic [NR_STREAMS-1:0]        snk_req,
    input  logic [NR_STREAMS-1:0]        snk_ack,
    output logic [DWIDTH-1:0]            snk_data,
    output logic [NR_STREAMS_LOG-1:0]    in_slot,
    output logic [NR_STREAMS_LOG-1:0]    out_slot,
    output logic [15:0]                  stuff_count
);
    localparam int WW = $clog2(STUFF_TIMEOUT + 2);
    localparam int DEPTH = 1 << FIFO_LOG;
    localparam logic [WW-1:0] TO = WW'(STUFF_TIMEOUT);
    localparam logic [NR_STREAMS_LOG-1:0] LAST = NR_STREAMS_LOG'(NR_STREAMS - 1);
    localparam logic [NR_STREAMS-1:0] ONE = NR_STREAMS'(1);

    typedef enum logic {WAIT, SEND} in_state_e;
    typedef enum logic {RECV, DELIVER} out_state_e;

    in_state_e                 in_state_q, in_state_d;
    out_state_e                out_state_q, out_state_d;
    logic [NR_STREAMS_LOG-1:0] in_slot_q, in_slot_d, out_slot_q, out_slot_d;
    logic [WW-1:0]             wait_cnt_q, wait_cnt_d;
    logic [DWIDTH-1:0]         data_q, data_d, snk_data_q, snk_data_d;
    logic                      tag_q, tag_d;
    logic [15:0]               stuff_q, stuff_d;
    logic [DEPTH-1:0]          fifo_q;
    logic [FIFO_LOG-1:0]       wr_q, rd_q;
    logic [FIFO_LOG:0]         cnt_q;
    logic                      full, empty, push, pop, real_req, stuff;

    function automatic logic [NR_STREAMS_LOG-1:0] nxt(input logic [NR_STREAMS_LOG-1:0] s);
        return s == LAST ? '0 : s + 1'b1;
    endfunction

    assign full        = cnt_q == (FIFO_LOG+1)'(DEPTH);
    assign empty       = cnt_q == '0;
    assign real_req    = src_req[in_slot_q];
    assign stuff       = STUFF_TIMEOUT > 0 && wait_cnt_q == TO && !real_req && !full;
    assign push        = in_state_q == SEND && flt_in_ack;
    assign pop         = flt_out_ack && flt_out_req;
    assign src_ack     = (in_state_q == WAIT && !full) ? ONE << in_slot_q : '0;
    assign flt_in_req  = in_state_q == SEND;
    assign flt_in_data = data_q;
    assign flt_out_ack = out_state_q == RECV && !empty;
    assign snk_req     = out_state_q == DELIVER ? ONE << out_slot_q : '0;
    assign snk_data    = snk_data_q;
    assign in_slot     = in_slot_q;
    assign out_slot    = out_slot_q;
    assign stuff_count = stuff_q;

    // input side: capture a real sample or stuff a zero after the idle timeout, then hand it to the filter
    always_comb begin
        in_state_d = in_state_q;
        in_slot_d  = in_slot_q;
        wait_cnt_d = wait_cnt_q;
        data_d     = data_q;
        tag_d      = tag_q;
        stuff_d    = stuff_q;
        if (in_state_q == WAIT) begin
            if (real_req && !full) begin
                data_d     = src_data[in_slot_q*DWIDTH +: DWIDTH];
                tag_d      = 1'b0;
                in_state_d = SEND;
            end else if (stuff) begin
                data_d     = '0;
                tag_d      = 1'b1;
                stuff_d    = stuff_q + {15'd0, stuff_q != 16'hFFFF};
                in_state_d = SEND;
            end else if (wait_cnt_q != TO) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end else if (flt_in_ack) begin
            in_slot_d  = nxt(in_slot_q);
            wait_cnt_d = '0;
            in_state_d = WAIT;
        end
    end

    // output side: pop a tag per filter result, drop stuffed results, hold real ones until the sink takes them
    always_comb begin
        out_state_d = out_state_q;
        out_slot_d  = out_slot_q;
        snk_data_d  = snk_data_q;
        if (pop) begin
            if (fifo_q[rd_q]) begin
                out_slot_d = nxt(out_slot_q);
            end else begin
                snk_data_d  = flt_out_data;
                out_state_d = DELIVER;
            end
        end else if (out_state_q == DELIVER && snk_ack[out_slot_q]) begin
            out_slot_d  = nxt(out_slot_q);
            out_state_d = RECV;
        end
    end

    // state registers and the in-flight tag FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q  <= WAIT;
            out_state_q <= RECV;
            in_slot_q   <= '0;
            out_slot_q  <= '0;
            wait_cnt_q  <= '0;
            data_q      <= '0;
            snk_data_q  <= '0;
            tag_q       <= 1'b0;
            stuff_q     <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            in_slot_q   <= in_slot_d;
            out_slot_q  <= out_slot_d;
            wait_cnt_q  <= wait_cnt_d;
            data_q      <= data_d;
            snk_data_q  <= snk_data_d;
            tag_q       <= tag_d;
            stuff_q     <= stuff_d;
            if (push) begin
                fifo_q[wr_q] <= tag_q;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{FIFO_LOG{1'b0}}, push} - {{FIFO_LOG{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_stream_scheduler.sv
// tb_stream_scheduler: directed tables and randomized traffic checked against a queue-based scheduler model
module tb_stream_scheduler;
    localparam int DW = 16, NS = 13, NL = 4, TO = 8, DEPTH = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic [NS-1:0] src_req, src_ack, snk_req, snk_ack;
    logic [NS*DW-1:0] src_data;
    logic flt_in_req, flt_in_ack, flt_out_req, flt_out_ack;
    logic [DW-1:0] flt_in_data, flt_out_data, snk_data;
    logic [NL-1:0] in_slot, out_slot;
    logic [15:0] stuff_count;

    stream_scheduler #(.DWIDTH(DW), .NR_STREAMS(NS), .NR_STREAMS_LOG(NL), .STUFF_TIMEOUT(TO), .FIFO_LOG(3)) dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_ack(src_ack), .src_data(src_data),
        .flt_in_req(flt_in_req), .flt_in_ack(flt_in_ack), .flt_in_data(flt_in_data),
        .flt_out_req(flt_out_req), .flt_out_ack(flt_out_ack), .flt_out_data(flt_out_data),
        .snk_req(snk_req), .snk_ack(snk_ack), .snk_data(snk_data),
        .in_slot(in_slot), .out_slot(out_slot), .stuff_count(stuff_count));

    always #5 clk = ~clk;

    typedef struct {logic [DW-1:0] d; int t;} fe_t;
    typedef struct {bit tag; logic [DW-1:0] d;} te_t;
    typedef struct {int slot; logic [DW-1:0] data; int stuff; int gap;} vec_t;

    int vectors = 0, errors = 0, cyc = 0, n_in = 0;
    int src_rate[NS];
    int in_ack_rate = 100, out_rate = 100, out_budget = 1 << 30, snk_rate = 100;
    bit fixed_data = 1'b1, bogus = 1'b0, oreq = 1'b0, in_x, out_x, snk5_seen;
    logic [NS-1:0] pend = '0, snk_block = '0, snk_x;
    int seqn[NS];
    fe_t fq[$];
    bit m_send, m_dlv, m_tag;
    int m_slot, m_oslot, m_idle, m_stuff;
    logic [DW-1:0] m_cap, m_sdata, in_x_d;
    int in_x_slot;
    te_t tq[$];
    vec_t tbl[15];

    function automatic logic [DW-1:0] xf(input logic [DW-1:0] d);
        return d ^ 16'hA5C3;
    endfunction

    function automatic int nx(input int s);
        return s == NS - 1 ? 0 : s + 1;
    endfunction

    function automatic logic [NS-1:0] oh(input int i);
        logic [NS-1:0] r = 1;
        return r << i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (!pend[i] && $urandom_range(99) < src_rate[i]) begin
                pend[i] = 1'b1;
                seqn[i]++;
            end
            src_data[i*DW +: DW] = fixed_data ? 16'h0100 + DW'(i) : {4'(i + 1), 12'(seqn[i])};
            snk_ack[i] = !snk_block[i] && $urandom_range(99) < snk_rate;
        end
        src_req = pend;
        flt_in_ack = $urandom_range(99) < in_ack_rate;
        if (!oreq && fq.size() > 0 && out_budget > 0 && $urandom_range(99) < out_rate && fq[0].t <= cyc) oreq = 1'b1;
        flt_out_req = oreq || bogus;
        flt_out_data = oreq ? xf(fq[0].d) : 16'hDEAD;
    endtask

    task automatic tick();
        logic [NS-1:0] src_x;
        logic [DW-1:0] fdata;
        bit fi_x, fo_x, full, ox, dd;
        te_t te;
        #1;
        full = tq.size() >= DEPTH;
        chk("src_ack", src_ack, (!m_send && !full) ? oh(m_slot) : '0);
        chk("flt_in_req", flt_in_req, m_send);
        if (m_send) chk("flt_in_data", flt_in_data, m_cap);
        chk("in_slot", in_slot, m_slot);
        chk("out_slot", out_slot, m_oslot);
        chk("stuff_count", stuff_count, m_stuff);
        chk("flt_out_ack", flt_out_ack, !m_dlv && tq.size() > 0);
        chk("snk_req", snk_req, m_dlv ? oh(m_oslot) : '0);
        if (m_dlv) chk("snk_data", snk_data, m_sdata);
        if (snk_req[5]) snk5_seen = 1'b1;
        ox = !m_dlv && tq.size() > 0 && flt_out_req;
        dd = m_dlv && snk_ack[m_oslot];
        if (!m_send) begin
            if (src_req[m_slot] && !full) begin
                m_cap = src_data[m_slot*DW +: DW];
                m_tag = 1'b0;
                m_send = 1'b1;
            end else if (m_idle == TO && !src_req[m_slot] && !full) begin
                m_cap = '0;
                m_tag = 1'b1;
                m_send = 1'b1;
                if (m_stuff < 65535) m_stuff++;
            end else if (m_idle < TO) m_idle++;
        end else if (flt_in_ack) begin
            tq.push_back('{m_tag, m_cap});
            m_slot = nx(m_slot);
            m_idle = 0;
            m_send = 1'b0;
        end
        if (ox) begin
            te = tq.pop_front();
            if (te.tag) m_oslot = nx(m_oslot);
            else begin
                m_dlv = 1'b1;
                m_sdata = xf(te.d);
            end
        end
        if (dd) begin
            m_dlv = 1'b0;
            m_oslot = nx(m_oslot);
        end
        src_x = src_req & src_ack;
        fi_x = flt_in_req && flt_in_ack;
        fo_x = flt_out_req && flt_out_ack;
        fdata = flt_in_data;
        in_x = fi_x;
        in_x_d = flt_in_data;
        in_x_slot = int'(in_slot);
        out_x = fo_x;
        snk_x = snk_req & snk_ack;
        @(posedge clk);
        cyc++;
        #1;
        pend &= ~src_x;
        if (fi_x) begin
            fq.push_back('{fdata, cyc + 3});
            n_in++;
        end
        if (fo_x && oreq) begin
            void'(fq.pop_front());
            oreq = 1'b0;
            out_budget--;
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc += 2;
        m_send = 0; m_dlv = 0; m_slot = 0; m_oslot = 0; m_idle = 0; m_stuff = 0; m_cap = '0; m_sdata = '0;
        tq.delete();
        fq.delete();
        oreq = 1'b0;
        pend = '0;
        n_in = 0;
        drive();
        chk("rst_flt_in_req", flt_in_req, 0);
        chk("rst_flt_in_data", flt_in_data, 0);
        chk("rst_snk_req", snk_req, 0);
        chk("rst_snk_data", snk_data, 0);
        chk("rst_in_slot", in_slot, 0);
        chk("rst_out_slot", out_slot, 0);
        chk("rst_stuff_count", stuff_count, 0);
        chk("rst_flt_out_ack", flt_out_ack, 0);
    endtask

    task automatic set_rates(input int r);
        for (int i = 0; i < NS; i++) src_rate[i] = r;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [DW-1:0] d0;
        for (int k = 0; k < 15; k++)
            tbl[k] = '{k % NS, (k % NS == 5) ? 16'h0000 : 16'h0100 + DW'(k % NS), (k >= 5) ? 1 : 0, (k % NS == 5) ? TO + 2 : 2};
        set_rates(100);
        src_rate[5] = 0;
        drive();
        do_reset();
        snk5_seen = 1'b0;
        for (int r = 0; r < 15; r++) begin
            n = 0;
            in_x = 1'b0;
            while (!in_x && n < 40) begin
                tick();
                n++;
            end
            chk("tbl_seen", in_x, 1);
            chk("tbl_slot", in_x_slot, tbl[r].slot);
            chk("tbl_data", in_x_d, tbl[r].data);
            chk("tbl_stuff", stuff_count, tbl[r].stuff);
            chk("tbl_gap", n, tbl[r].gap);
        end
        repeat (40) tick();
        chk("tbl_snk5_never", snk5_seen, 0);

        set_rates(0);
        do_reset();
        bogus = 1'b1;
        drive();
        repeat (5) tick();
        bogus = 1'b0;
        drive();
        repeat (20) tick();
        chk("idle_stuff_count", stuff_count, 2);

        set_rates(100);
        out_budget = 0;
        do_reset();
        repeat (40) tick();
        chk("hold_in_count", n_in, 8);
        chk("hold_src_ack", src_ack, 0);
        out_budget = 1;
        drive();
        repeat (30) tick();
        chk("hold_one_more", n_in, 9);

        out_budget = 1 << 30;
        snk_block = oh(2);
        do_reset();
        n = 0;
        while (!snk_req[2] && n < 100) begin
            tick();
            n++;
        end
        chk("stall_seen", snk_req[2], 1);
        d0 = snk_data;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_snk_req", snk_req, oh(2));
            chk("stall_snk_data", snk_data, d0);
            chk("stall_flt_out_ack", flt_out_ack, 0);
        end
        snk_block = '0;
        drive();
        n = 0;
        snk_x = '0;
        while (!snk_x[2] && n < 10) begin
            tick();
            n++;
        end
        chk("stall_delivered", snk_x[2], 1);
        chk("stall_out_slot", out_slot, 3);

        src_rate[3] = 0;
        do_reset();
        n = 0;
        while (!(in_slot == 7 && flt_in_req) && n < 100) begin
            tick();
            n++;
        end
        chk("mid_reached", in_slot == 7 && flt_in_req, 1);
        chk("mid_stuffed", stuff_count, 1);
        in_ack_rate = 0;
        drive();
        do_reset();
        chk("mid_fifo_empty", dut.cnt_q, 0);
        in_ack_rate = 100;
        src_rate[3] = 100;

        src_rate[0] = 0;
        out_budget = 0;
        do_reset();
        n = 0;
        while (n_in < 4 && n < 100) begin
            tick();
            n++;
        end
        in_ack_rate = 0;
        drive();
        n = 0;
        while (!flt_in_req && n < 20) begin
            tick();
            n++;
        end
        chk("fifo_cnt4", dut.cnt_q, 4);
        in_ack_rate = 100;
        out_budget = 1;
        drive();
        tick();
        chk("fifo_push", in_x, 1);
        chk("fifo_pop", out_x, 1);
        chk("fifo_cnt_same", dut.cnt_q, 4);
        chk("fifo_oldest_out_slot", out_slot, 1);
        chk("fifo_oldest_no_deliver", snk_req, 0);

        fixed_data = 1'b0;
        in_ack_rate = 70;
        out_rate = 60;
        snk_rate = 60;
        out_budget = 1 << 30;
        do_reset();
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < NS; i++) src_rate[i] = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(100, 20));
            repeat (500) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/stream_scheduler.md
Name: stream_scheduler

Overview:
- Round-robin scheduler that time-multiplexes NR_STREAMS independent producers onto the single shared multi-stream filter input.
- Routes the filter's in-order output samples back to per-stream consumers.
- Keeps the filter's slot sequence intact by zero-stuffing a slot whose producer stays silent for too long; the stuffed result is discarded on return.
- Sits between the per-stream sources/sinks and the filter's req/ack ports.

Parameters:
- DWIDTH, 16, sample width in bits.
- NR_STREAMS, 13, number of multiplexed streams (≥2).
- NR_STREAMS_LOG, 4, slot counter width; 2^NR_STREAMS_LOG ≥ NR_STREAMS.
- STUFF_TIMEOUT, 8, idle WAIT cycles before zero-stuffing a slot; 0 disables stuffing.
- FIFO_LOG, 3, log2 depth of the in-flight slot-tag FIFO; depth is 2^FIFO_LOG.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- src_req  in  NR_STREAMS  per-stream input request.
- src_ack  out  NR_STREAMS  per-stream input acknowledge (combinational).
- src_data  in  NR_STREAMS*DWIDTH  stream i occupies bits i*DWIDTH .. i*DWIDTH+DWIDTH-1.
- flt_in_req  out  1  sample valid towards the filter.
- flt_in_ack  in  1  filter accepts the sample.
- flt_in_data  out  DWIDTH  sample to the filter.
- flt_out_req  in  1  filter output valid.
- flt_out_ack  out  1  output accepted (combinational).
- flt_out_data  in  DWIDTH  filter output sample.
- snk_req  out  NR_STREAMS  per-stream output valid; one-hot or zero.
- snk_ack  in  NR_STREAMS  per-stream sink accept.
- snk_data  out  DWIDTH  output sample, shared by all sinks.
- in_slot  out  NR_STREAMS_LOG  stream index currently scheduled on the input side.
- out_slot  out  NR_STREAMS_LOG  stream index expected next on the output side.
- stuff_count  out  16  number of stuffed samples, saturating.

Behaviour:
- Handshake rule: a transfer occurs on a rising edge where req and ack are both 1. The requester holds req and data stable until that transfer.
- Reset:
  - Input FSM goes to WAIT; output FSM goes to RECV.
  - in_slot = out_slot = 0; FIFO emptied; wait_cnt = 0; stuff_count = 0.
  - Outputs: flt_in_req = 0, flt_in_data = 0, all snk_req = 0, snk_data = 0.
  - Reset mid-operation drops any captured or in-flight sample without acking it.
- Input FSM, WAIT state:
  - src_ack[i] = (i == in_slot) && !fifo_full; all other bits are 0.
  - On a src transfer: capture src_data slice, tag = 0, go to SEND. flt_in_req is high in the next cycle, giving 1-cycle latency.
  - Otherwise wait_cnt increments.
  - Stuffing: if STUFF_TIMEOUT > 0, wait_cnt == STUFF_TIMEOUT, src_req[in_slot] = 0 and the FIFO is not full, then capture 0 with tag = 1, increment stuff_count (saturates at 0xFFFF) and go to SEND.
  - A real request arriving in the timeout cycle wins over stuffing.
  - wait_cnt clears on entry to WAIT.
- Input FSM, SEND state:
  - flt_in_req = 1 with the captured data.
  - On the filter transfer: push the tag into the FIFO, advance in_slot (NR_STREAMS-1 wraps to 0), go to WAIT.
  - src_ack is all 0 in SEND.
- Output FSM, RECV state:
  - flt_out_ack = !fifo_empty.
  - flt_out_req while the FIFO is empty is a protocol violation: it is held off (ack = 0) and nothing else changes.
  - On a transfer: pop the tag.
    - Tag = 1: discard the sample, advance out_slot, stay in RECV.
    - Tag = 0: register flt_out_data into snk_data and go to DELIVER.
- Output FSM, DELIVER state:
  - snk_req[out_slot] = 1; flt_out_ack = 0.
  - On snk_ack[out_slot] transfer: advance out_slot with wrap, return to RECV.
  - snk_ack on any other bit is ignored.
- FIFO:
  - Depth 2^FIFO_LOG, 1-bit tags, count-based full/empty flags.
  - A simultaneous push and pop is legal: count unchanged, order preserved.
  - Full blocks new input captures only; SEND completes regardless.
- Input and output sides are fully independent and may progress in the same cycle.

Test Plan:
- All sources always requesting, stream i data = 0x0100+i, filter modelled as a 3-cycle loopback -> flt_in_data sequence 0x0100..0x010C repeating, one src_ack per stream per round, snk_req[i] delivers 0x0100+i in order, stuff_count = 0.
- Stream 5 silent, STUFF_TIMEOUT = 8 -> after 8 idle WAIT cycles in slot 5, flt_in_data = 0 with stuff_count = 1; snk_req[5] is never asserted; slot 6 data follows normally.
- flt_out_req held 0, all sources requesting -> exactly 8 input samples reach the filter, then src_ack stays 0; one output transfer -> exactly one more input is accepted.
- snk_ack[2] held 0 for 20 cycles -> snk_req[2] and snk_data stay stable, flt_out_ack = 0 throughout; release -> delivery completes and out_slot = 3.
- rst pulsed while in_slot = 7 and in SEND -> in the cycle after reset release flt_in_req = 0, in_slot = 0, out_slot = 0, FIFO empty, stuff_count = 0.
- FIFO at count 4, push and pop on the same edge -> count stays 4, popped tag equals the oldest pushed tag.
